// File: rtl/car_physics_pkg.sv
// Shared map, terrain and fixed-point definitions for the car physics engine, renderer and color decoder.
// Positions are Q10.4 unsigned per axis; trig values are Q1.7 signed (+128 == 1.0).
package car_physics_pkg;

   localparam int MAP_WIDTH  = 320;
   localparam int MAP_HEIGHT = 240;
   localparam int MAP_ADDR_W = 17;

   localparam logic [3:0] IDX_ROAD  = 4'd0;
   localparam logic [3:0] IDX_GRASS = 4'd1;
   localparam logic [3:0] IDX_WALL  = 4'd5;

   localparam int TRIG_W    = 9;
   localparam int TRIG_FRAC = 7;
   localparam int POS_W     = 14;
   localparam int POS_FRAC  = 4;

   typedef logic signed [TRIG_W-1:0] trig_t;
   typedef logic [POS_W-1:0]         pos_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STEER,
      ST_MOVE,
      ST_ADDR,
      ST_WAIT,
      ST_CHECK
   } phys_state_t;

   function automatic logic [MAP_ADDR_W-1:0] map_address(input logic [9:0] x, input logic [9:0] y);
      return {7'd0, y} * 17'(MAP_WIDTH) + {7'd0, x};
   endfunction

endpackage

// File: rtl/car_physics_trig_lut.sv
// Combinational heading -> sin/cos lookup in Q1.7, folded from a single 0..90 degree quadrant table.
module car_physics_trig_lut
   import car_physics_pkg::*;
(
   input  logic [8:0] degree,
   output trig_t      sin_q,
   output trig_t      cos_q
);

   // round(128 * sin(d)) for d = 0..90
   localparam int QSIN [0:90] = '{
        0,   2,   4,   7,   9,  11,  13,  16,  18,  20,
       22,  24,  27,  29,  31,  33,  35,  37,  40,  42,
       44,  46,  48,  50,  52,  54,  56,  58,  60,  62,
       64,  66,  68,  70,  72,  73,  75,  77,  79,  81,
       82,  84,  86,  87,  89,  91,  92,  94,  95,  97,
       98,  99, 101, 102, 104, 105, 106, 107, 109, 110,
      111, 112, 113, 114, 115, 116, 117, 118, 119, 119,
      120, 121, 122, 122, 123, 124, 124, 125, 125, 126,
      126, 126, 127, 127, 127, 128, 128, 128, 128, 128,
      128
   };

   logic [6:0] sin_idx;
   logic [6:0] cos_idx;
   logic       sin_neg;
   logic       cos_neg;

   function automatic trig_t apply_sign(input int mag, input logic neg);
      return trig_t'(neg ? -mag : mag);
   endfunction

   always_comb begin
      sin_idx = '0;
      cos_idx = '0;
      sin_neg = 1'b0;
      cos_neg = 1'b0;
      if (degree <= 9'd90) begin
         sin_idx = 7'(degree);
         cos_idx = 7'(9'd90 - degree);
      end else if (degree <= 9'd180) begin
         sin_idx = 7'(9'd180 - degree);
         cos_idx = 7'(degree - 9'd90);
         cos_neg = 1'b1;
      end else if (degree <= 9'd270) begin
         sin_idx = 7'(degree - 9'd180);
         cos_idx = 7'(9'd270 - degree);
         sin_neg = 1'b1;
         cos_neg = 1'b1;
      end else begin
         sin_idx = 7'(9'd360 - degree);
         cos_idx = 7'(degree - 9'd270);
         sin_neg = 1'b1;
      end
   end

   assign sin_q = apply_sign(QSIN[sin_idx], sin_neg);
   assign cos_q = apply_sign(QSIN[cos_idx], cos_neg);

endmodule

// File: rtl/car_physics.sv
// Per-player motion engine: on each frame tick it steers, throttles, moves to a candidate position,
// reads the terrain under it from the map BRAM and commits or reverts the move.
module car_physics
   import car_physics_pkg::*;
#(
   parameter int START_X   = 15,
   parameter int START_Y   = 125,
   parameter int START_DEG = 0,
   parameter int DEG_STEP  = 15,
   parameter int ACCEL     = 4,
   parameter int BRAKE     = 8,
   parameter int FRICTION  = 1,
   parameter int MAX_SPEED = 48,
   parameter int GRASS_MAX = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        accel,
   input  logic        brake,
   input  logic        steer_left,
   input  logic        steer_right,
   output logic [16:0] map_addr,
   input  logic [3:0]  map_index,
   output logic [9:0]  world_x,
   output logic [9:0]  world_y,
   output logic [8:0]  degree,
   output logic [5:0]  speed,
   output logic        busy,
   output logic        done
);

   localparam logic signed [15:0] X_LIMIT = 16'(MAP_WIDTH << POS_FRAC);
   localparam logic signed [15:0] Y_LIMIT = 16'(MAP_HEIGHT << POS_FRAC);

   phys_state_t state;
   phys_state_t next_state;

   pos_t pos_x;
   pos_t pos_y;
   logic grass;

   logic              accel_p0, brake_p0, left_p0, right_p0;
   logic [8:0]        deg_p1;
   logic [5:0]        spd_p1;
   logic signed [15:0] cand_x_p2, cand_y_p2;
   logic              oob_p3;

   trig_t              sin_q, cos_q;
   logic signed [15:0] spd_s, sin_s, cos_s;
   logic signed [15:0] prod_x, prod_y, dx, dy, nx, ny;
   logic               oob;

   function automatic logic [8:0] turn(input logic [8:0] d, input logic l, input logic r);
      int nd;
      nd = int'(d);
      if (l && !r) nd = nd + DEG_STEP;
      else if (r && !l) nd = nd + 360 - DEG_STEP;
      if (nd >= 360) nd = nd - 360;
      return 9'(nd);
   endfunction

   function automatic logic [5:0] sat_sub(input logic [5:0] s, input int dec);
      return (int'(s) > dec) ? 6'(int'(s) - dec) : 6'd0;
   endfunction

   function automatic logic [5:0] cap_speed(input int s, input int cap);
      return (s > cap) ? 6'(cap) : 6'(s);
   endfunction

   function automatic logic [5:0] throttle(input logic [5:0] s, input logic a, input logic b,
                                           input logic on_grass);
      if (b) return sat_sub(s, BRAKE);
      if (a) return cap_speed(int'(s) + ACCEL, on_grass ? GRASS_MAX : MAX_SPEED);
      return sat_sub(s, FRICTION);
   endfunction

   car_physics_trig_lut u_trig_lut (
      .degree (deg_p1),
      .sin_q  (sin_q),
      .cos_q  (cos_q)
   );

   // MOVE: displacement in 1/16 px from the staged speed and new heading
   always_comb begin
      spd_s  = {10'd0, spd_p1};
      sin_s  = {{7{sin_q[TRIG_W-1]}}, sin_q};
      cos_s  = {{7{cos_q[TRIG_W-1]}}, cos_q};
      prod_x = spd_s * cos_s;
      prod_y = spd_s * sin_s;
      dx     = prod_x >>> TRIG_FRAC;
      dy     = prod_y >>> TRIG_FRAC;
      nx     = $signed({2'b00, pos_x}) + dx;
      ny     = $signed({2'b00, pos_y}) + dy;
   end

   assign oob = cand_x_p2[15] || cand_y_p2[15] || (cand_x_p2 >= X_LIMIT) || (cand_y_p2 >= Y_LIMIT);

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (tick) next_state = ST_STEER;
         ST_STEER: next_state = ST_MOVE;
         ST_MOVE:  next_state = ST_ADDR;
         ST_ADDR:  next_state = ST_WAIT;
         ST_WAIT:  next_state = ST_CHECK;
         ST_CHECK: next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // Staged datapath: _p0 latched controls, _p1 steer result, _p2 candidate, _p3 bounds verdict
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && tick) begin
         accel_p0 <= accel;
         brake_p0 <= brake;
         left_p0  <= steer_left;
         right_p0 <= steer_right;
      end
      if (state == ST_STEER) begin
         deg_p1 <= turn(degree, left_p0, right_p0);
         spd_p1 <= throttle(speed, accel_p0, brake_p0, grass);
      end
      if (state == ST_MOVE) begin
         cand_x_p2 <= nx;
         cand_y_p2 <= ny;
      end
      if (state == ST_ADDR) oob_p3 <= oob;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_x    <= pos_t'(START_X << POS_FRAC);
         pos_y    <= pos_t'(START_Y << POS_FRAC);
         degree   <= 9'(START_DEG);
         speed    <= '0;
         grass    <= 1'b0;
         map_addr <= '0;
         done     <= 1'b0;
      end else begin
         done <= (state == ST_CHECK);
         if (state == ST_ADDR && !oob)
            map_addr <= map_address(cand_x_p2[13:4], cand_y_p2[13:4]);
         // CHECK: out-of-bounds behaves like a wall; the new heading is kept either way
         if (state == ST_CHECK) begin
            degree <= deg_p1;
            if (oob_p3) begin
               speed <= '0;
            end else begin
               case (map_index)
                  IDX_WALL: speed <= '0;
                  IDX_GRASS: begin
                     pos_x <= cand_x_p2[13:0];
                     pos_y <= cand_y_p2[13:0];
                     speed <= cap_speed(int'(spd_p1), GRASS_MAX);
                     grass <= 1'b1;
                  end
                  default: begin
                     pos_x <= cand_x_p2[13:0];
                     pos_y <= cand_y_p2[13:0];
                     speed <= spd_p1;
                     grass <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign world_x = pos_x[13:4];
   assign world_y = pos_y[13:4];
   assign busy    = (state != ST_IDLE);

endmodule
